seg_scan_mux: RTL
=================

Name: seg_scan_mux

Overview:
Time-multiplexed seven-segment scan driver, sitting directly downstream of the per-digit seven-segment decoders.
- Takes the packed segment patterns for NUM_DIGITS digits and drives one shared set of segment lines plus per-digit enables.
- Cycles through the digits with a programmable slot length.
- Inserts a blanking interval at the start of every slot to suppress ghosting.
- Emits a one-cycle frame tick after each full scan.

Parameters:
NUM_DIGITS, 2, number of digits scanned (>=1)
SCAN_DIV, 50000, clk cycles per digit slot (>=2)
BLANK_CYCLES, 1000, cycles at slot start with all digits off (0 <= BLANK_CYCLES < SCAN_DIV)
IDX_W, $clog2(NUM_DIGITS) min 1, width of digit_idx

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  scan enable; 0 = blank and hold at digit 0
seg_in  in  7*NUM_DIGITS  active-low patterns; digit i at [7i+6:7i], digit 0 at LSBs
dp_in  in  NUM_DIGITS  active-low decimal points; bit i = digit i
seg_out  out  7  shared segment lines, active-low
dp_out  out  1  shared decimal point, active-low
an_out  out  NUM_DIGITS  digit enables, active-low, at most one low
digit_idx  out  IDX_W  index of the digit currently selected
frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-high (rst).
  - rst=1 immediately sets cnt=0 and idx=0.
  - Outputs during reset: an_out=all 1s, seg_out=7'h7F, dp_out=1, digit_idx=0, frame_tick=0.
  - rst asserted mid-slot aborts the slot immediately.
- Registered state: cnt (0..SCAN_DIV-1), idx (0..NUM_DIGITS-1). All outputs are registers; no combinational path from inputs to outputs.
- Counting with en=1:
  - cnt increments each edge.
  - When cnt==SCAN_DIV-1: cnt->0, and idx->idx+1, or idx->0 if idx==NUM_DIGITS-1.
- Two states per slot, derived from the post-edge cnt:
  - BLANK: cnt<BLANK_CYCLES.
  - SHOW: cnt>=BLANK_CYCLES.
- Output update on each edge, using the post-edge cnt/idx:
  - BLANK: an_out=all 1s, seg_out=7'h7F, dp_out=1.
  - SHOW: an_out has only bit idx low; seg_out=seg_in[7idx+6:7idx] and dp_out=dp_in[idx], both sampled at that edge.
  - Latency from seg_in/dp_in to seg_out/dp_out is 1 cycle.
- digit_idx mirrors idx every cycle, including during BLANK.
- frame_tick:
  - Is 1 for exactly the cycle following an edge where idx wrapped NUM_DIGITS-1 -> 0; otherwise 0.
  - With NUM_DIGITS=1, it pulses at every slot end.
- en=0 (sampled at an edge):
  - That edge sets cnt=0, idx=0, digit_idx=0, frame_tick=0, and blanks the outputs.
  - State is held while en stays 0.
- en re-asserted: counting resumes from cnt=0 / digit 0, so the first slot is a full slot.
- BLANK_CYCLES=0: no blanking. Once the first edge with en=1 has been taken, an_out is never all 1s.
- Frame period: NUM_DIGITS*SCAN_DIV cycles.
- seg_in changes mid-SHOW are reflected on the next edge; no glitch filtering.

Test Plan:
Bench parameters: NUM_DIGITS=2, SCAN_DIV=8, BLANK_CYCLES=2, seg_in={7'h79,7'h40}, dp_in=2'b10, en=1. Edges are counted from reset release.

1. Reset:
   - Hold rst=1 -> an_out=2'b11, seg_out=7'h7F, dp_out=1, digit_idx=0, frame_tick=0.
   - Assert rst asynchronously mid-SHOW -> outputs blank before the next edge.
2. Normal scan:
   - Edge 1: blank.
   - Edges 2-7: an_out=2'b10, seg_out=7'h40, dp_out=0.
   - Edge 8: idx=1, blank.
   - Edges 10-15: an_out=2'b01, seg_out=7'h79, dp_out=1.
   - Edge 16: idx=0; frame_tick=1 for one cycle only. Repeats every 16 cycles.
3. Data change:
   - Set seg_in[6:0]=7'h24 while the bench is in SHOW of digit 0 -> seg_out=7'h24 after the next edge.
   - an_out is unchanged.
4. Enable:
   - Drop en at edge 11 (digit 1, SHOW) -> next edge: blank, digit_idx=0, frame_tick=0; held for 5 cycles.
   - Raise en -> 2 blank cycles, then digit 0 shown for 6 cycles.
5. Parameter sweep 1: BLANK_CYCLES=0 -> an_out never 2'b11 after the first edge; slots are 8 cycles each.
6. Parameter sweep 2: NUM_DIGITS=3, SCAN_DIV=4, BLANK_CYCLES=1 -> digit_idx sequence 0,1,2,0 every 4 cycles; frame_tick period 12 cycles.

Source files
------------

// File: rtl/seg_scan_mux.sv
// ============================================================================
//  seg_scan_mux : time-multiplexed seven-segment scan driver with slot
//                 blanking and a one-cycle frame tick.
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module seg_scan_mux #(
  parameter int NUM_DIGITS   = 2,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  localparam int                 CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   BLANK_C = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  tick_q, tick_d;
  logic                  blank_phase;

  // Phase decode works on the post-edge count so outputs line up with it.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign blank_phase = 1'b0;
    end else begin : g_blank
      assign blank_phase = (cnt_d < BLANK_C);
    end
  endgenerate

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    tick_d = 1'b0;
    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d  = '0;
        tick_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (en && !blank_phase) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_d = seg_in[int'(idx_d)*7 +: 7];
      dp_d  = dp_in[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule

`default_nettype wire
